// File: rtl/result_buffer_reader.sv
// result_buffer_reader: drains the decrypted-text buffer from data RAM
// one byte at a time onto a valid/ready stream.
module result_buffer_reader #(
  parameter int BASE_ADDR   = 1500,
  parameter int LEN         = 108,
  parameter int STOP_ON_NUL = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] ram_addr,
  output logic        ram_rd_en,
  input  logic [31:0] ram_data,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [7:0]  LAST = 8'(LEN - 1);
  localparam logic [11:0] BASE = 12'(BASE_ADDR);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_idx;
  logic [7:0]  w_idx;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt;
  logic [7:0]  r_byte;
  logic [7:0]  w_byte;
  logic [11:0] r_addr;
  logic [11:0] w_addr;
  logic        r_valid;
  logic        r_rd_en;
  logic        r_done;
  logic        w_accept;
  logic        w_nul;
  logic        w_busy_nxt;
  logic        w_unused;

  assign w_unused = ^ram_data[31:8];
  assign w_accept = (r_state == S_PRESENT) && out_ready;
  assign w_nul    = (STOP_ON_NUL != 0) && (ram_data[7:0] == 8'h00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:    if (start) w_next = S_ISSUE;
        S_ISSUE:   w_next = S_WAIT;
        S_WAIT:    w_next = w_nul ? S_DONE : S_PRESENT;
        S_PRESENT: if (w_accept)
                     w_next = (r_idx == LAST) ? S_DONE : S_ISSUE;
        S_DONE:    w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the transition.
  always_comb begin
    w_idx  = r_idx;
    w_cnt  = r_cnt;
    w_byte = r_byte;
    if (!abort) begin
      unique case (r_state)
        S_IDLE: if (start) begin
          w_idx = 8'd0;
          w_cnt = 8'd0;
        end
        S_WAIT:    w_byte = ram_data[7:0];
        S_PRESENT: if (w_accept) begin
          w_cnt = r_cnt + 8'd1;
          if (r_idx != LAST) w_idx = r_idx + 8'd1;
        end
        default: ;
      endcase
    end
    w_busy_nxt = (w_next == S_ISSUE) || (w_next == S_WAIT) ||
                 (w_next == S_PRESENT);
    w_addr = w_busy_nxt ? BASE + {4'd0, w_idx} : 12'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= 8'd0;
      r_cnt   <= 8'd0;
      r_byte  <= 8'd0;
      r_addr  <= 12'd0;
      r_valid <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_byte  <= w_byte;
      r_addr  <= w_addr;
      r_valid <= (w_next == S_PRESENT);
      r_rd_en <= (w_next == S_ISSUE);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign busy       = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                      (r_state == S_PRESENT);
  assign ram_addr   = r_addr;
  assign ram_rd_en  = r_rd_en;
  assign out_byte   = r_byte;
  assign out_valid  = r_valid;
  assign done       = r_done;
  assign byte_count = r_cnt;

endmodule

// File: tb/tb_result_buffer_reader.sv
// tb_result_buffer_reader: scoreboard bench for result_buffer_reader
// with a RAM model, random data and random consumer backpressure.
module tb_result_buffer_reader;

  localparam int BASE = 1500;
  localparam int LEN  = 108;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] ram_addr;
  logic        ram_rd_en;
  logic [31:0] ram_data = 32'd0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [7:0]  byte_count;

  logic [31:0] mem [4096];
  logic [7:0]  exp_q [$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int rmode = 3;
  int hold = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'd0;
  logic [11:0] prev_addr = 12'd0;

  result_buffer_reader #(
    .BASE_ADDR(BASE), .LEN(LEN), .STOP_ON_NUL(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_data(ram_data),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_rd_en"}, ram_rd_en, 0);
    chk({tag, "_byte"}, out_byte, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, byte_count, 0);
  endtask

  // Reference: bytes come from RAM in order until LEN words or a NUL.
  function automatic int model_expect();
    int n = 0;
    logic [7:0] b;
    for (int i = 0; i < LEN; i++) begin
      b = mem[BASE + i][7:0];
      if (b == 8'h00) break;
      exp_q.push_back(b);
      n++;
    end
    return n;
  endfunction

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", out_byte, prev_byte);
        chk("hold_addr", ram_addr, prev_addr);
      end
      if (done) n_done++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
        else chk("stream_byte", out_byte, exp_q.pop_front());
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_addr  = ram_addr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Consumer: 0 always ready, 1 random, 2 stall byte 3, else never.
  always @(posedge clock) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: if (n_acc == 3 && hold < 10) begin
           out_ready = 1'b0;
           if (out_valid) hold++;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = 1'b0;
    endcase
  end

  task automatic drain(input bit mid_start, input bit chk_time,
                       input int extra);
    int n_exp;
    int t0;
    int k;
    int d0;
    n_exp = model_expect();
    n_acc = 0;
    hold = 0;
    d0 = n_done;
    @(posedge clock); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    chk("c1_rd_en", ram_rd_en, 1);
    chk("c1_addr", ram_addr, BASE);
    chk("c1_busy", busy, 1);
    @(posedge clock); #1;
    chk("c2_rd_en", ram_rd_en, 0);
    chk("c2_valid", out_valid, 0);
    @(posedge clock); #1;
    chk("c3_valid", out_valid, 1);
    k = 0;
    while (!done && k < 5000) begin
      if (mid_start) start = (k % 37 == 5);
      @(posedge clock); #1;
      k++;
    end
    chk("done_seen", done, 1);
    if (chk_time)
      chk("done_cycle", cyc - t0,
          (n_exp == LEN ? 3 * LEN + 1 : 3 * n_exp + 3) + extra);
    chk("byte_count", byte_count, n_exp);
    chk("queue_empty", exp_q.size(), 0);
    start = mid_start;
    @(posedge clock); #1;
    start = 1'b0;
    chk("done_pulse", done, 0);
    chk("after_busy", busy, 0);
    chk("after_addr", ram_addr, 0);
    @(posedge clock); #1;
    chk("stay_idle", busy, 0);
    chk("stay_idle_rd", ram_rd_en, 0);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int k;
    int d0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    #1;
    chk_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Full alphabet drain, with ignored start pulses while busy/DONE.
    for (int i = 0; i < LEN; i++)
      mem[BASE + i] = {24'($urandom), 8'(8'h41 + i % 26)};
    rmode = 0;
    drain(1'b1, 1'b1, 0);

    // Early NUL stop at word 5.
    mem[BASE + 5] = 32'hABCDEF00;
    drain(1'b0, 1'b1, 0);
    mem[BASE + 5] = {24'($urandom), 8'h46};

    // Ten cycles of backpressure on byte 3.
    rmode = 2;
    drain(1'b0, 1'b1, 10);

    // Abort while waiting on the RAM for byte 50.
    rmode = 0;
    void'(model_expect());
    n_acc = 0;
    d0 = n_done;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (!(n_acc == 49 && ram_rd_en) && k < 1000) begin
      @(posedge clock); #1;
      k++;
    end
    chk("abort_reach", n_acc, 49);
    @(posedge clock); #1;
    chk("abort_in_wait", busy && !ram_rd_en && !out_valid, 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_count", byte_count, 49);
    chk("abort_addr", ram_addr, 0);
    exp_q.delete();
    repeat (5) @(posedge clock);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_still_idle", busy, 0);
    drain(1'b0, 1'b1, 0);

    // Asynchronous reset in the middle of PRESENT.
    rmode = 3;
    void'(model_expect());
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clock); #1;
      k++;
    end
    chk("rst_present", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;

    // start and abort together in IDLE.
    rmode = 0;
    @(posedge clock); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_rd_en", ram_rd_en, 0);
    @(posedge clock); #1;
    chk("sa_busy2", busy, 0);
    chk("sa_count", byte_count, 0);

    // Random contents with occasional NULs, random consumer.
    rmode = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LEN; i++) begin
        mem[BASE + i][31:8] = 24'($urandom);
        if (i > 0 && $urandom_range(0, 39) == 0)
          mem[BASE + i][7:0] = 8'h00;
        else
          mem[BASE + i][7:0] = 8'($urandom_range(1, 255));
      end
      drain(1'b0, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_buffer_reader.md
# result_buffer_reader

Sequential reader that drains the decrypted-text buffer from processor data RAM after the CPU finishes, presenting one byte at a time on a valid/ready stream toward the display/UART side. It sits beside the RAM port mux. It owns the RAM address only while busy. It is the read-back counterpart of the character-buffer write path that fills RAM at address 1500 onward.

## Interface
Parameters:
- BASE_ADDR, 1500, first RAM word address of the buffer
- LEN, 108, number of words to read; legal range 1..255
- STOP_ON_NUL, 1, when 1, a word whose low byte is 8'h00 ends the transfer early; that byte is not emitted

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  one-cycle request to begin a drain; sampled only in IDLE
- abort  in  1  synchronous cancel; returns the block to IDLE on the next edge
- ram_addr  out  12  RAM word address; equals BASE_ADDR + idx while busy, 0 otherwise
- ram_rd_en  out  1  high in ISSUE; the wrapper uses it to steer the RAM address mux
- ram_data  in  32  RAM dataOut; valid one cycle after the address is presented
- out_byte  out  8  current character, ram_data[7:0] as captured
- out_valid  out  1  out_byte is valid; held until accepted
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse on completion or early NUL stop; not raised on abort
- byte_count  out  8  number of bytes accepted in the current or most recent drain

## Operation
- States:
  - IDLE: start → ISSUE, with idx cleared to 0 and byte_count cleared to 0.
  - ISSUE: present the address, ram_rd_en=1 → WAIT.
  - WAIT: capture ram_data[7:0] into out_byte at the closing edge. If STOP_ON_NUL and the byte is 0 → DONE; else → PRESENT.
  - PRESENT: out_valid=1. On acceptance, byte_count+1. Then if idx==LEN-1 → DONE; else idx+1 → ISSUE.
  - DONE: done=1 for one cycle → IDLE.
- idx is an 8-bit counter. ram_addr = BASE_ADDR + idx, truncated to 12 bits; wrap past 4095 is the integrator's responsibility.
- out_byte and out_valid are stable while out_valid=1 && out_ready=0. The byte must not change before acceptance.
- start while busy or in DONE is ignored. start and abort in the same IDLE cycle: abort wins, so the block stays IDLE.
- abort in any state → IDLE at the next edge:
  - out_valid drops.
  - byte_count keeps the accepted count.
  - done stays 0.
- Upper ram_data bits [31:8] are ignored.

## Timing
- Reset values of all outputs are 0. State is IDLE and idx is 0.
- Reset asserted mid-transfer drops out_valid and busy asynchronously. The in-flight byte is lost.
- Start latency, counting the cycle in which start is sampled high as cycle 0:
  - cycle 1: ISSUE, ram_rd_en=1
  - cycle 2: WAIT
  - cycle 3: out_valid=1
- Throughput with out_ready held high is one byte per 3 cycles. A full drain of LEN=108 takes start → done in 3·108+1 = 325 cycles; done is high in cycle 325.
- out_ready may be high before out_valid. Acceptance happens only in a cycle where both are high.
- busy is combinational from state; all other outputs are registered.

## Test plan
- Preload RAM[1500..1607] = 0x41+i mod 26 and hold out_ready=1. Pulse start. Required: 108 bytes 'A','B',…; done in cycle 325; byte_count=108; busy low after.
- STOP_ON_NUL=1 with RAM[1505]=0. Required: 5 bytes emitted, then done; byte_count=5; no 0x00 byte on the stream.
- Backpressure: drop out_ready for 10 cycles while out_valid=1 on byte 3. Required: out_byte held constant, idx/ram_addr not advanced; stream resumes correctly, final count 108.
- Abort in WAIT during byte 50. Required: IDLE next cycle, out_valid=0, done never pulses, byte_count=49. A new start then drains from 1500.
- Assert reset=0 asynchronously mid-PRESENT. Required: all outputs 0 before the next edge.
- Pulse start while busy, and start with abort together in IDLE. Required: both are ignored, with no state change.
